// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, start/busy/done handshake.
// Optional subtract mode (sub port, a - b) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Handshake: start is sampled only in IDLE; busy marks the WIDTH RUN cycles;
  // done pulses for one cycle when sum/cout have just been updated.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Two half adders plus an OR form the full adder for the current bit.
  logic ha0_s, ha0_c, ha1_c, bit_s, bit_co;
  assign ha0_s  = ra_q[0] ^ rb_q[0];
  assign ha0_c  = ra_q[0] & rb_q[0];
  assign bit_s  = ha0_s ^ c_q;
  assign ha1_c  = ha0_s & c_q;
  assign bit_co = ha0_c | ha1_c;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
`ifdef SERIAL_ADDER_SUB_EN
  // a - b is a + ~b + 1, so the inverted operand enters with carry-in set.
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  assign b_load = b;
  assign c_load = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rs_d  = {bit_s, rs_q[WIDTH-1:1]};
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        c_d   = bit_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {bit_s, rs_q[WIDTH-1:1]};
          cout_d  = bit_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for handshake, timing and
// reset behaviour, and a 4-bit instance swept over every operand pair.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8;
`endif

  serial_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub8),
`endif
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .start(start4),
    .a    (a4),
    .b    (b4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (1'b0),
`endif
    .busy (busy4),
    .done (done4),
    .sum  (sum4),
    .cout (cout4)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] hold8 = '0;
  logic [4:0] hold4 = '0;
  logic       rst_s = 1'b1;
  int         cyc = 0;
  int         done8_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    if (s) return {(x >= y), 8'(x - y)};
    return {1'b0, x} + {1'b0, y};
  endfunction

  always @(posedge clk) begin
    rst_s <= rst;
    cyc   <= cyc + 1;
  end

  // Result monitors: pop on done, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst_s) hold8 = '0;
    if (done8) begin
      done8_cyc = cyc;
      check("busy_done_excl8", {31'd0, busy8}, 32'd0);
      if (exp8_q.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        hold8 = exp8_q.pop_front();
        check("result8", {23'd0, cout8, sum8}, {23'd0, hold8});
      end
    end else begin
      check("hold8", {23'd0, cout8, sum8}, {23'd0, hold8});
    end
  end

  always @(negedge clk) begin
    if (rst_s) hold4 = '0;
    if (done4) begin
      if (exp4_q.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        hold4 = exp4_q.pop_front();
        check("result4", {27'd0, cout4, sum4}, {27'd0, hold4});
      end
    end else begin
      check("hold4", {27'd0, cout4, sum4}, {27'd0, hold4});
    end
  end

  // Drives start for exactly one edge; caller must be in an IDLE cycle.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s, input bit push);
    start8 = 1'b1;
    a8     = x;
    b8     = y;
`ifdef SERIAL_ADDER_SUB_EN
    sub8   = s;
`endif
    if (push) exp8_q.push_back(model8(x, y, s));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
  endtask

  task automatic wait_done8(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("done_timeout8", 32'd0, 32'd1);
  endtask

  task automatic issue4(input logic [3:0] x, input logic [3:0] y);
    start4 = 1'b1;
    a4     = x;
    b4     = y;
    exp4_q.push_back({1'b0, x} + {1'b0, y});
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
  endtask

  task automatic wait_done4();
    bit seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout4", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, d1;
    logic [7:0] rx, ry;
    rst    = 1'b1;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);

    // 0+0: busy for WIDTH cycles, done in the cycle after E8.
    issue8(8'h00, 8'h00, 1'b0, 1'b1);
    wait_done8(lat, nb);
    check("lat_zero", lat, 32'd9);
    check("busy_cycles", nb, 32'd8);

    // Result holds between done pulses.
    @(posedge clk); #1;
    issue8(8'h5A, 8'h33, 1'b0, 1'b1);
    wait_done8(lat, nb);
    repeat (3) @(negedge clk);
    issue8(8'hFF, 8'h01, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("sum_held", {24'd0, sum8}, 32'h8D);
    wait_done8(lat, nb);

    // start during RUN and DONE is ignored; next accept is the edge after DONE ends.
    @(posedge clk); #1;
    issue8(8'h0F, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, nb);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    d1 = done8_cyc;
    issue8(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done8(lat, nb);
    check("b2b_lat", lat, 32'd9);
    @(posedge clk); #1;
    check("b2b_gap", done8_cyc - d1, 32'd10);

    // Reset sampled on E4 aborts the operation and clears the result.
    issue8(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sum", {24'd0, sum8}, 32'd0);
    check("abort_cout", {31'd0, cout8}, 32'd0);
    check("abort_busy", {31'd0, busy8}, 32'd0);
    issue8(8'h80, 8'h80, 1'b0, 1'b1);
    wait_done8(lat, nb);
    check("post_rst_lat", lat, 32'd9);

`ifdef SERIAL_ADDER_SUB_EN
    @(posedge clk); #1;
    issue8(8'h10, 8'h01, 1'b1, 1'b1);
    wait_done8(lat, nb);
    @(posedge clk); #1;
    issue8(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done8(lat, nb);
    @(posedge clk); #1;
    issue8(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done8(lat, nb);
`endif

    for (int n = 0; n < 12; n++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
`ifdef SERIAL_ADDER_SUB_EN
      issue8(rx, ry, 1'($urandom_range(0, 1)), 1'b1);
`else
      issue8(rx, ry, 1'b0, 1'b1);
`endif
      wait_done8(lat, nb);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        issue4(4'(i), 4'(j));
        wait_done4();
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty8", exp8_q.size(), 32'd0);
    check("queue_empty4", exp4_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
